passthrough_stream_fifo_mc: RTL and testbench
=============================================

# passthrough_stream_fifo_mc

Multi-channel successor of the passthrough stream FIFO: `NumChan` independent FIFO queues, each `Depth` entries of `DataWidth` bits, in one block. Each channel has its own push/pop handshake and flush, a fill-level output and an almost-full flag. Each channel is passthrough: a full channel still accepts a push in the same cycle it is popped. Used at multi-stream DMA and NoC endpoints, where per-channel FIFOs are currently instantiated one by one.

## Interface
- `NumChan`, 4: number of independent channels, ≥1
- `Depth`, 8: entries per channel, ≥1, any value (not restricted to powers of two)
- `DataWidth`, 8: payload bits per entry
- `SameCycleRW`, 1: 1 = a full channel accepts a push when popped in the same cycle
- `AlmostFullThresh`, 6: `almost_full_o[c]` asserts when usage ≥ this value; range 1..Depth
- Derived `CntW` = $clog2(Depth+1)

Ports:
- `clk_i`  in  1  single clock, all state on rising edge
- `rst_i`  in  1  reset, synchronous and active-high
- `flush_i`  in  NumChan  per-channel synchronous clear
- `data_i`  in  NumChan*DataWidth  push payload; channel c is in slice [c*DataWidth +: DataWidth]
- `valid_i`  in  NumChan  push strobe; must only be high when `ready_o[c]` is high
- `ready_o`  out  NumChan  channel can accept a push this cycle
- `data_o`  out  NumChan*DataWidth  head entry of each channel
- `valid_o`  out  NumChan  channel is non-empty
- `ready_i`  in  NumChan  pop strobe; must only be high when `valid_o[c]` is high
- `usage_o`  out  NumChan*CntW  current entry count per channel
- `almost_full_o`  out  NumChan  usage ≥ `AlmostFullThresh`
- `err_o`  out  NumChan  sticky protocol-error flag (see Configuration)

## Operation
- Per channel state: read pointer, write pointer and usage counter.
- Storage: one `Depth`×`DataWidth` array per channel.
- Pointer wrap: each pointer increments modulo `Depth` (Depth-1 → 0); correct for non-power-of-2 depths.
- Push: occurs when `valid_i[c]` is high. Writes `data_i` slice at wptr, then wptr+1.
- Pop: occurs when `ready_i[c]` is high. Advances rptr.
- Usage update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `valid_o[c]` = (usage ≠ 0); `data_o[c]` = mem[c][rptr] (combinational read).
- `ready_o[c]` = !rst_i && !flush_i[c] && (usage < Depth || (SameCycleRW && ready_i[c])).
- Empty channel: data is never forwarded from input to output; a push into an empty channel becomes visible on the next cycle.
- Flush: `flush_i[c]` sets rptr, wptr and usage to 0 and takes priority over push and pop in the same cycle. Storage contents are not cleared; `err_o` is not cleared.
- Channels are fully independent; no arbitration or shared storage between them.

## Timing
- Reset (`rst_i` high at a clock edge):
  - all pointers, usage and `err_o` go to 0
  - while `rst_i` is high: `ready_o` = 0, `valid_o` = 0, `usage_o` = 0, `almost_full_o` = 0
  - `data_o` is don't-care
- Reset asserted mid-operation discards all entries; there is no drain.
- First push is accepted in the cycle after `rst_i` is sampled low.
- Latency: a push at edge N is visible on `valid_o` / `data_o` after edge N; minimum latency 1 cycle.
- Throughput: 1 push and 1 pop per channel per cycle, including when full if `SameCycleRW`=1.
- Full with `SameCycleRW`=0: `ready_o` = 0 until a pop has taken effect (after the edge).
- `usage_o` and `almost_full_o` are registered-state derived; they reflect the state after the last edge.
- `Depth`=1: valid configuration; with `SameCycleRW`=1 it sustains 1 entry per cycle when the consumer is always ready.

## Configuration
- Macro `PASSTHROUGH_STREAM_FIFO_MC_ERR_EN`.
- Defined:
  - `err_o[c]` sets when `valid_i[c]` is high while `ready_o[c]` is low (overflow), or `ready_i[c]` is high while `valid_o[c]` is low (underflow).
  - It stays set until `rst_i`.
  - The offending push or pop is ignored: no pointer or usage change.
- Not defined:
  - `err_o` is tied to 0 and the error logic is absent.
  - An offending push or pop is also ignored (state gated on `ready_o` / `valid_o`).

## Test plan
- Reset then single push: `rst_i` high 3 cycles, then push 0xA5 on ch0 → `ready_o`=0 during reset; `valid_o[0]`=1 and `data_o[0]`=0xA5 one cycle after the push edge; `usage_o[0]`=1.
- Fill and wrap, Depth=5: push 0..4, pop 3, push 5..7 → pops return 0..7 in order, `usage_o` tracks each step, `almost_full_o` high at usage ≥ `AlmostFullThresh`.
- Passthrough on full: ch1 full (Depth=8), `SameCycleRW`=1, pop and push 0x3C in the same cycle → push accepted, usage stays 8, 0x3C emerges 8 pops later. With `SameCycleRW`=0 → `ready_o[1]`=0 in that cycle.
- Flush with concurrent push: ch2 holds 4 entries, assert `flush_i[2]` with `valid_i[2]` → next cycle usage=0, `valid_o[2]`=0, other channels unchanged.
- Randomised independent traffic on all 4 channels (push/pop probability 1/10), 1000 items each → per-channel scoreboard shows zero mismatches and no cross-channel leakage.
- Error flag with `PASSTHROUGH_STREAM_FIFO_MC_ERR_EN`: pop empty ch3 → `err_o[3]`=1 next cycle, usage stays 0; `err_o[3]` stays 1 until `rst_i`. Without the macro → `err_o`=0.

Source files
------------

// File: rtl/passthrough_stream_fifo_mc.sv
// ============================================================================
// Module   : passthrough_stream_fifo_mc
// Brief    : NumChan independent passthrough FIFOs (Depth x DataWidth each)
//            with per-channel push/pop handshake, flush, fill level and
//            almost-full flag. A full channel accepts a push in the same
//            cycle it is popped when SameCycleRW is set.
//            Optional macro PASSTHROUGH_STREAM_FIFO_MC_ERR_EN enables the
//            sticky per-channel protocol-error flag on err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module passthrough_stream_fifo_mc #(
  parameter int NumChan          = 4,
  parameter int Depth            = 8,
  parameter int DataWidth        = 8,
  parameter int SameCycleRW      = 1,
  parameter int AlmostFullThresh = 6,
  localparam int CntW            = $clog2(Depth + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumChan-1:0]             flush_i,
  input  logic [NumChan*DataWidth-1:0]   data_i,
  input  logic [NumChan-1:0]             valid_i,
  output logic [NumChan-1:0]             ready_o,
  output logic [NumChan*DataWidth-1:0]   data_o,
  output logic [NumChan-1:0]             valid_o,
  input  logic [NumChan-1:0]             ready_i,
  output logic [NumChan*CntW-1:0]        usage_o,
  output logic [NumChan-1:0]             almost_full_o,
  output logic [NumChan-1:0]             err_o
);

  // Depth=1 still needs a one-bit pointer so the storage index is legal.
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] c_PTR_LAST = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] c_DEPTH    = CntW'(Depth);
  localparam logic [CntW-1:0] c_AF_LVL   = CntW'(AlmostFullThresh);

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [DataWidth-1:0] r_mem [Depth];
    logic [PtrW-1:0]      r_rptr;
    logic [PtrW-1:0]      r_wptr;
    logic [CntW-1:0]      r_usage;

    logic                 w_ready;
    logic                 w_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [PtrW-1:0]      w_rptr_nxt;
    logic [PtrW-1:0]      w_wptr_nxt;

    // Outputs are forced quiet while reset is held, even before the first edge.
    assign w_valid = !rst_i && (r_usage != '0);
    assign w_ready = !rst_i && !flush_i[c] &&
                     ((r_usage < c_DEPTH) || ((SameCycleRW != 0) && ready_i[c]));

    // Offending strobes are ignored by gating on the handshake; flush beats both.
    assign w_push = valid_i[c] && w_ready;
    assign w_pop  = ready_i[c] && w_valid && !flush_i[c];

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_rptr_nxt = (r_rptr == c_PTR_LAST) ? '0 : r_rptr + PtrW'(1);
    assign w_wptr_nxt = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + PtrW'(1);

    // Storage write; contents survive reset and flush, only pointers clear.
    always_ff @(posedge clk_i) begin
      if (w_push) begin
        r_mem[r_wptr] <= data_i[c*DataWidth +: DataWidth];
      end
    end

    // Pointer and usage bookkeeping with reset and flush priority.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i[c]) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_usage <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= w_wptr_nxt;
        end
        if (w_pop) begin
          r_rptr <= w_rptr_nxt;
        end
        case ({w_push, w_pop})
          2'b10:   r_usage <= r_usage + CntW'(1);
          2'b01:   r_usage <= r_usage - CntW'(1);
          default: r_usage <= r_usage;
        endcase
      end
    end

`ifdef PASSTHROUGH_STREAM_FIFO_MC_ERR_EN
    logic r_err;

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_err <= 1'b0;
      end else if ((valid_i[c] && !w_ready) || (ready_i[c] && !w_valid)) begin
        r_err <= 1'b1;
      end
    end

    assign err_o[c] = r_err;
`else
    assign err_o[c] = 1'b0;
`endif

    assign ready_o[c]                           = w_ready;
    assign valid_o[c]                           = w_valid;
    assign data_o[c*DataWidth +: DataWidth]     = r_mem[r_rptr];
    assign usage_o[c*CntW +: CntW]              = rst_i ? '0 : r_usage;
    assign almost_full_o[c]                     = !rst_i && (r_usage >= c_AF_LVL);
  end

endmodule

`default_nettype wire

// File: tb/tb_passthrough_stream_fifo_mc.sv
// ============================================================================
// Module   : tb_passthrough_stream_fifo_mc
// Brief    : Self-checking bench for passthrough_stream_fifo_mc. A default
//            4x8 instance and a single-channel Depth=5, SameCycleRW=0 one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_passthrough_stream_fifo_mc;

  logic        clk;
  logic        rst;
  logic [3:0]  flush;
  logic [3:0]  valid;
  logic [3:0]  ready_in;
  logic [31:0] din;
  logic [3:0]  ready_out;
  logic [31:0] dout;
  logic [3:0]  valid_out;
  logic [15:0] usage;
  logic [3:0]  afull;
  logic [3:0]  err;

  logic        f5;
  logic        v5;
  logic        r5;
  logic [7:0]  d5;
  logic        rdy5;
  logic [7:0]  do5;
  logic        vo5;
  logic [2:0]  u5;
  logic        af5;
  logic        e5;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] q_t [$];
  q_t sbq [4];
  q_t q5;

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  v;
    logic [3:0]  r;
    logic [31:0] d;
    logic [15:0] exp_usage;
    logic [3:0]  exp_af;
  } vec_t;
  vec_t tbl [10];

  passthrough_stream_fifo_mc u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .data_i        (din),
    .valid_i       (valid),
    .ready_o       (ready_out),
    .data_o        (dout),
    .valid_o       (valid_out),
    .ready_i       (ready_in),
    .usage_o       (usage),
    .almost_full_o (afull),
    .err_o         (err)
  );

  passthrough_stream_fifo_mc #(
    .NumChan          (1),
    .Depth            (5),
    .DataWidth        (8),
    .SameCycleRW      (0),
    .AlmostFullThresh (4)
  ) u_dut5 (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (f5),
    .data_i        (d5),
    .valid_i       (v5),
    .ready_o       (rdy5),
    .data_o        (do5),
    .valid_o       (vo5),
    .ready_i       (r5),
    .usage_o       (u5),
    .almost_full_o (af5),
    .err_o         (e5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of traffic on the 4-channel instance, scoreboarded per channel.
  task automatic cycle(input logic [3:0] f, input logic [3:0] v,
                       input logic [31:0] d, input logic [3:0] r);
    logic [3:0] er;
    flush = f; valid = v; din = d; ready_in = r;
    #1;
    for (int c = 0; c < 4; c++) begin
      er[c] = !f[c] && ((sbq[c].size() < 8) || r[c]);
      if (r[c]) begin
        chk($sformatf("valid_o_ch%0d_at_pop", c), valid_out[c], sbq[c].size() != 0);
        if (sbq[c].size() != 0)
          chk($sformatf("data_o_ch%0d", c), dout[c*8 +: 8], sbq[c][0]);
      end
      if (v[c])
        chk($sformatf("ready_o_ch%0d", c), ready_out[c], er[c]);
    end
    for (int c = 0; c < 4; c++) begin
      if (f[c]) begin
        sbq[c].delete();
      end else begin
        if (r[c] && sbq[c].size() != 0) void'(sbq[c].pop_front());
        if (v[c] && er[c]) sbq[c].push_back(d[c*8 +: 8]);
      end
    end
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("usage_ch%0d", c), usage[c*4 +: 4], sbq[c].size());
      chk($sformatf("valid_ch%0d", c), valid_out[c], sbq[c].size() != 0);
      chk($sformatf("afull_ch%0d", c), afull[c], sbq[c].size() >= 6);
    end
  endtask

  // One clock on the Depth=5, SameCycleRW=0 instance.
  task automatic cycle5(input logic v, input logic [7:0] d, input logic r);
    logic er;
    v5 = v; d5 = d; r5 = r;
    #1;
    er = q5.size() < 5;
    if (r) begin
      chk("d5_valid_at_pop", vo5, q5.size() != 0);
      if (q5.size() != 0) chk("d5_data", do5, q5[0]);
    end
    if (v) chk("d5_ready", rdy5, er);
    if (r && q5.size() != 0) void'(q5.pop_front());
    if (v && er) q5.push_back(d);
    @(posedge clk); #1;
    chk("d5_usage", u5, q5.size());
    chk("d5_afull", af5, q5.size() >= 4);
  endtask

  initial begin
    int pushed [4];
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic [31:0] rd;
    logic        done;

    tbl[0] = '{4'b0000, 4'b0001, 4'b0000, 32'h000000A5, 16'h0001, 4'b0000};
    tbl[1] = '{4'b0000, 4'b0101, 4'b0000, 32'h00100001, 16'h0102, 4'b0000};
    tbl[2] = '{4'b0000, 4'b0101, 4'b0000, 32'h00110002, 16'h0203, 4'b0000};
    tbl[3] = '{4'b0000, 4'b0101, 4'b0000, 32'h00120003, 16'h0304, 4'b0000};
    tbl[4] = '{4'b0000, 4'b0101, 4'b0000, 32'h00130004, 16'h0405, 4'b0000};
    tbl[5] = '{4'b0000, 4'b0001, 4'b0000, 32'h00000005, 16'h0406, 4'b0001};
    tbl[6] = '{4'b0000, 4'b0001, 4'b0001, 32'h00000006, 16'h0406, 4'b0001};
    tbl[7] = '{4'b0100, 4'b0110, 4'b0000, 32'h00997700, 16'h0016, 4'b0001};
    tbl[8] = '{4'b0000, 4'b0000, 4'b0011, 32'h00000000, 16'h0005, 4'b0000};
    tbl[9] = '{4'b0000, 4'b0000, 4'b0001, 32'h00000000, 16'h0004, 4'b0000};

    // Reset held three cycles with pushes offered on every channel.
    rst = 1'b1; flush = '0; valid = 4'hF; ready_in = '0; din = 32'hDEADBEEF;
    f5 = 1'b0; v5 = 1'b0; r5 = 1'b0; d5 = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_ready", ready_out, 4'h0);
      chk("rst_valid", valid_out, 4'h0);
      chk("rst_usage", usage, 16'h0);
      chk("rst_afull", afull, 4'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0; valid = '0;
    #1;
    chk("post_rst_ready", ready_out, 4'hF);
    chk("post_rst_usage", usage, 16'h0);

    // Directed table: pushes, passthrough at mid-fill, flush with push.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_usage", i), usage, tbl[i].exp_usage);
      chk($sformatf("tbl%0d_afull", i), afull, tbl[i].exp_af);
      if (i == 0) chk("first_push_data", dout[7:0], 8'hA5);
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 32'h0, 4'b0001);

    // Full channel 1: no ready without a pop, passthrough with one.
    for (int i = 0; i < 8; i++) cycle(4'b0000, 4'b0010, 32'(8'h80 + i) << 8, 4'b0000);
    flush = '0; valid = '0; ready_in = '0;
    #1;
    chk("full_ch1_ready_no_pop", ready_out[1], 1'b0);
    cycle(4'b0000, 4'b0010, 32'h00003C00, 4'b0010);
    chk("full_passthrough_usage", usage[7:4], 4'd8);
    for (int i = 0; i < 8; i++) cycle(4'b0000, 4'b0000, 32'h0, 4'b0010);

    // Reset mid-operation discards everything.
    cycle(4'b0000, 4'b1001, 32'h5A00005A, 4'b0000);
    cycle(4'b0000, 4'b1001, 32'h5B00005B, 4'b0000);
    rst = 1'b1;
    #1;
    chk("midrst_ready", ready_out, 4'h0);
    chk("midrst_valid", valid_out, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) sbq[c].delete();
    cycle(4'b0000, 4'b0000, 32'h0, 4'b0000);
    chk("midrst_usage", usage, 16'h0);

    // Randomised independent traffic on all channels.
    for (int c = 0; c < 4; c++) pushed[c] = 0;
    done = 1'b0;
    for (int n = 0; n < 30000 && !done; n++) begin
      for (int c = 0; c < 4; c++) begin
        rr[c] = (sbq[c].size() != 0) && ($urandom_range(0, 9) == 0);
        rv[c] = (pushed[c] < 1000) && ((sbq[c].size() < 8) || rr[c]) &&
                ($urandom_range(0, 9) == 0);
        if (rv[c]) pushed[c]++;
      end
      rd = $urandom;
      cycle(4'b0000, rv, rd, rr);
      done = (pushed[0] >= 1000) && (pushed[1] >= 1000) &&
             (pushed[2] >= 1000) && (pushed[3] >= 1000);
    end
    chk("random_completed", done, 1'b1);
    for (int n = 0; n < 10; n++) cycle(4'b0000, 4'b0000, 32'h0, 4'b1111);
    chk("random_drained", usage, 16'h0);

    // Depth=5 instance: fill, rejected push on full, wrap, order check.
    for (int i = 0; i < 5; i++) cycle5(1'b1, 8'(i), 1'b0);
    cycle5(1'b1, 8'hEE, 1'b1);
    cycle5(1'b0, 8'h00, 1'b1);
    cycle5(1'b0, 8'h00, 1'b1);
    for (int i = 5; i < 8; i++) cycle5(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) cycle5(1'b0, 8'h00, 1'b1);
    chk("d5_empty", vo5, 1'b0);

`ifdef PASSTHROUGH_STREAM_FIFO_MC_ERR_EN
    ready_in = 4'b1000; valid = '0; flush = '0;
    @(posedge clk); #1;
    ready_in = '0;
    chk("err_ch3_set", err[3], 1'b1);
    chk("err_ch3_usage", usage[15:12], 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("err_ch3_sticky", err[3], 1'b1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared_by_rst", err, 4'h0);
`else
    ready_in = 4'b1000; valid = '0; flush = '0;
    @(posedge clk); #1;
    ready_in = '0;
    chk("err_tied_low", err, 4'h0);
    chk("err5_tied_low", e5, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
